// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and format helpers for the floating-point unit.
package fpu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_RSVD = 2'b11
    } fpu_op_e;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fpu_flags_t;

    function automatic int fmt_width(input int exp_w, input int mant_w);
        return 1 + exp_w + mant_w;
    endfunction

    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int exp_max(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// fpu_lzc: leading-zero counter; an all-zero input reports WIDTH.
module fpu_lzc #(
    parameter int WIDTH = 27,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CW-1:0]    count
);

    // Scan upward from the LSB so the highest set bit decides the count.
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) count = CW'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fpu_core.sv
// fpu_core: multi-cycle add/sub/mul unit for IEEE-754-style binary formats.
// One operation in flight; subnormal inputs and results are flushed to zero.
module fpu_core
    import fpu_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+MANT_W:0]   op_a,
    input  logic [EXP_W+MANT_W:0]   op_b,
    input  logic [1:0]              op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MANT_W:0]   result,
    output logic [3:0]              flags
);

    localparam int W   = fmt_width(EXP_W, MANT_W);
    localparam int SW  = MANT_W + 5;
    localparam int XW  = EXP_W + 2;
    localparam int LZW = $clog2(MANT_W + 5);

    localparam logic signed [XW-1:0] BIAS     = XW'(exp_bias(EXP_W));
    localparam logic signed [XW-1:0] EXP_SAT  = XW'(exp_max(EXP_W));
    localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
    localparam logic [EXP_W-1:0]     SHIFT_LIMIT = EXP_W'(MANT_W + 3);
    localparam logic [W-1:0]         QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
    localparam logic [W-2:0]         INF_MAG  = {{EXP_W{1'b1}}, {MANT_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE, CLASSIFY, ALIGN, ADD, MUL, NORM, ROUND, DONE
    } state_e;

    state_e              state;
    logic [W-1:0]        a_r, b_r;
    fpu_op_e             op_r;
    logic                big_sign, small_sign;
    logic [EXP_W-1:0]    big_exp, small_exp;
    logic [MANT_W:0]     big_sig, small_sig;
    logic [MANT_W+3:0]   small_al;
    logic                w_sign;
    logic signed [XW-1:0] w_exp;
    logic [SW-1:0]       w_sig;

    logic                a_sign, b_sign_eff;
    logic [EXP_W-1:0]    a_exp, b_exp;
    logic [MANT_W-1:0]   a_frac, b_frac;
    logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic [MANT_W:0]     a_sig, b_sig;

    assign a_sign     = a_r[W-1];
    assign b_sign_eff = b_r[W-1] ^ (op_r == OP_SUB);
    assign a_exp      = a_r[W-2:MANT_W];
    assign b_exp      = b_r[W-2:MANT_W];
    assign a_frac     = a_r[MANT_W-1:0];
    assign b_frac     = b_r[MANT_W-1:0];
    assign a_zero     = (a_exp == '0);
    assign b_zero     = (b_exp == '0);
    assign a_inf      = (a_exp == '1) && (a_frac == '0);
    assign b_inf      = (b_exp == '1) && (b_frac == '0);
    assign a_nan      = (a_exp == '1) && (a_frac != '0);
    assign b_nan      = (b_exp == '1) && (b_frac != '0);
    assign a_snan     = a_nan && !a_frac[MANT_W-1];
    assign b_snan     = b_nan && !b_frac[MANT_W-1];
    assign a_sig      = a_zero ? '0 : {1'b1, a_frac};
    assign b_sig      = b_zero ? '0 : {1'b1, b_frac};

    logic        cls_special;
    logic [W-1:0] cls_result;
    fpu_flags_t  cls_flags;

    // Pick out NaN/infinity/reserved-op cases that skip the arithmetic path.
    always_comb begin
        cls_special = 1'b0;
        cls_result  = QNAN;
        cls_flags   = '0;
        if (op_r == OP_RSVD) begin
            cls_special       = 1'b1;
            cls_flags.invalid = 1'b1;
        end else if (a_nan || b_nan) begin
            cls_special       = 1'b1;
            cls_flags.invalid = a_snan || b_snan;
        end else if (op_r == OP_MUL) begin
            if ((a_inf && b_zero) || (a_zero && b_inf)) begin
                cls_special       = 1'b1;
                cls_flags.invalid = 1'b1;
            end else if (a_inf || b_inf) begin
                cls_special = 1'b1;
                cls_result  = {a_sign ^ b_sign_eff, INF_MAG};
            end
        end else begin
            if (a_inf && b_inf && (a_sign != b_sign_eff)) begin
                cls_special       = 1'b1;
                cls_flags.invalid = 1'b1;
            end else if (a_inf) begin
                cls_special = 1'b1;
                cls_result  = {a_sign, INF_MAG};
            end else if (b_inf) begin
                cls_special = 1'b1;
                cls_result  = {b_sign_eff, INF_MAG};
            end
        end
    end

    logic [EXP_W-1:0]  shift_amt;
    logic [MANT_W+3:0] small_ext, lost_mask, align_val;

    // Right-align the smaller significand, folding shifted-out bits into sticky.
    always_comb begin
        shift_amt = big_exp - small_exp;
        small_ext = {small_sig, 3'b000};
        lost_mask = ~({(MANT_W+4){1'b1}} << shift_amt);
        if (shift_amt >= SHIFT_LIMIT) begin
            align_val = {{(MANT_W+3){1'b0}}, |small_sig};
        end else begin
            align_val = (small_ext >> shift_amt)
                      | {{(MANT_W+3){1'b0}}, |(small_ext & lost_mask)};
        end
    end

    logic [SW-1:0] big_w, small_w, add_sig;
    logic          add_sign;

    // Signed-magnitude add; an exact zero is negative only when both inputs are.
    always_comb begin
        big_w   = {1'b0, big_sig, 3'b000};
        small_w = {1'b0, small_al};
        if (big_sign == small_sign) begin
            add_sig  = big_w + small_w;
            add_sign = big_sign;
        end else if (big_w >= small_w) begin
            add_sig  = big_w - small_w;
            add_sign = big_sign;
        end else begin
            add_sig  = small_w - big_w;
            add_sign = small_sign;
        end
        if (add_sig == '0) add_sign = big_sign & small_sign;
    end

    logic [2*MANT_W+1:0]  prod;
    logic [SW-1:0]        mul_sig;
    logic signed [XW-1:0] mul_exp;

    // Full significand product; bits below the round position collapse to sticky.
    always_comb begin
        prod    = {{(MANT_W+1){1'b0}}, big_sig} * {{(MANT_W+1){1'b0}}, small_sig};
        mul_sig = {prod[2*MANT_W+1:MANT_W-2], |prod[MANT_W-3:0]};
        mul_exp = $signed({2'b00, big_exp}) + $signed({2'b00, small_exp}) - BIAS;
    end

    logic [LZW-1:0]       lz;
    logic [SW-1:0]        norm_sig;
    logic signed [XW-1:0] norm_exp;

    fpu_lzc #(.WIDTH(MANT_W + 4)) u_lzc (
        .value (w_sig[SW-2:0]),
        .count (lz)
    );

    // Normalise: one-bit right shift on carry-out, otherwise left by leading zeros.
    always_comb begin
        if (w_sig[SW-1]) begin
            norm_sig = {1'b0, w_sig[SW-1:2], w_sig[1] | w_sig[0]};
            norm_exp = w_exp + EXP_ONE;
        end else begin
            norm_sig = w_sig << lz;
            norm_exp = w_exp - $signed({{(XW-LZW){1'b0}}, lz});
        end
    end

    logic                 guard, rnd, stk, round_up;
    logic [MANT_W+1:0]    mant_rnd;
    logic [MANT_W-1:0]    frac_fin;
    logic signed [XW-1:0] exp_rnd;
    logic [W-1:0]         rnd_result;
    fpu_flags_t           rnd_flags;

    // Round to nearest even, then saturate to infinity or flush to zero.
    always_comb begin
        guard    = w_sig[2];
        rnd      = w_sig[1];
        stk      = w_sig[0];
        round_up = guard & (rnd | stk | w_sig[3]);
        mant_rnd = {1'b0, w_sig[SW-2:3]} + {{(MANT_W+1){1'b0}}, round_up};
        if (mant_rnd[MANT_W+1]) begin
            frac_fin = mant_rnd[MANT_W:1];
            exp_rnd  = w_exp + EXP_ONE;
        end else begin
            frac_fin = mant_rnd[MANT_W-1:0];
            exp_rnd  = w_exp;
        end
        rnd_flags = '0;
        if (w_sig == '0) begin
            rnd_result = {w_sign, {(W-1){1'b0}}};
        end else if (exp_rnd >= EXP_SAT) begin
            rnd_result         = {w_sign, INF_MAG};
            rnd_flags.overflow = 1'b1;
            rnd_flags.inexact  = 1'b1;
        end else if (exp_rnd[XW-1] || (exp_rnd == '0)) begin
            rnd_result          = {w_sign, {(W-1){1'b0}}};
            rnd_flags.underflow = 1'b1;
            rnd_flags.inexact   = 1'b1;
        end else begin
            rnd_result        = {w_sign, exp_rnd[EXP_W-1:0], frac_fin};
            rnd_flags.inexact = guard | rnd | stk;
        end
    end

    // Control FSM stepping one operation through the datapath stages.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= op_a;
                        b_r      <= op_b;
                        op_r     <= fpu_op_e'(op);
                        in_ready <= 1'b0;
                        state    <= CLASSIFY;
                    end
                end
                CLASSIFY: begin
                    if (cls_special) begin
                        result    <= cls_result;
                        flags     <= cls_flags;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        if (a_exp >= b_exp) begin
                            big_sign   <= a_sign;
                            big_exp    <= a_exp;
                            big_sig    <= a_sig;
                            small_sign <= b_sign_eff;
                            small_exp  <= b_exp;
                            small_sig  <= b_sig;
                        end else begin
                            big_sign   <= b_sign_eff;
                            big_exp    <= b_exp;
                            big_sig    <= b_sig;
                            small_sign <= a_sign;
                            small_exp  <= a_exp;
                            small_sig  <= a_sig;
                        end
                        w_sign <= a_sign ^ b_sign_eff;
                        state  <= (op_r == OP_MUL) ? MUL : ALIGN;
                    end
                end
                ALIGN: begin
                    small_al <= align_val;
                    state    <= ADD;
                end
                ADD: begin
                    w_sig  <= add_sig;
                    w_sign <= add_sign;
                    w_exp  <= $signed({2'b00, big_exp});
                    state  <= NORM;
                end
                MUL: begin
                    w_sig <= mul_sig;
                    w_exp <= mul_exp;
                    state <= NORM;
                end
                NORM: begin
                    w_sig <= norm_sig;
                    w_exp <= norm_exp;
                    state <= ROUND;
                end
                ROUND: begin
                    result    <= rnd_result;
                    flags     <= rnd_flags;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_core.sv
// tb_fpu_core: scoreboard bench for fpu_core in single-precision configuration.
module tb_fpu_core;

    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;
    localparam int W        = 32;
    localparam int MAX_WAIT = 50;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a, op_b;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    typedef struct {
        logic [W-1:0] result;
        logic [3:0]   flags;
        int           latency;
    } expect_t;

    expect_t scoreboard[$];
    int      check_count = 0;
    int      pass_count  = 0;

    fpu_core #(.EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    // Hard stop in case the DUT wedges the handshake entirely.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", check_count);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic driveOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o);
        @(negedge clock);
        op_a     = a;
        op_b     = b;
        op       = o;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o,
                                 input logic [W-1:0] exp_result, input logic [3:0] exp_flags,
                                 input int exp_latency);
        expect_t e;
        e.result  = exp_result;
        e.flags   = exp_flags;
        e.latency = exp_latency;
        scoreboard.push_back(e);
        driveOp(a, b, o);
    endtask

    task automatic collectResult(input string tag, input int hold);
        expect_t e;
        int      lat;
        lat = 1;
        checkOutput({tag, "_busy"}, {63'd0, in_ready}, 64'd0);
        while (!out_valid && lat < MAX_WAIT) begin
            @(negedge clock);
            lat++;
        end
        if (scoreboard.size() == 0) begin
            checkOutput({tag, "_sb_entry"}, 64'd0, 64'd1);
            return;
        end
        e = scoreboard.pop_front();
        checkOutput({tag, "_latency"}, 64'(lat), 64'(e.latency));
        if (!out_valid) return;
        checkOutput({tag, "_result"}, 64'(result), 64'(e.result));
        checkOutput({tag, "_flags"}, 64'(flags), 64'(e.flags));
        if (hold > 0) begin
            out_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clock);
                checkOutput({tag, "_hold"}, {26'd0, out_valid, in_ready, result, flags},
                            {26'd0, 1'b1, 1'b0, e.result, e.flags});
            end
            out_ready = 1'b1;
        end
        @(negedge clock);
        checkOutput({tag, "_released"}, {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b1;
        op_a      = 32'h3F800000;
        op_b      = 32'h3F800000;
        op        = 2'b00;
        out_ready = 1'b1;
        $display("[TB] starting fpu_core bench");

        repeat (2) @(negedge clock);
        checkOutput("reset_state", {26'd0, in_ready, out_valid, result, flags},
                    {26'd0, 1'b1, 1'b0, 32'h0, 4'h0});
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("post_reset_idle", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});

        applyStimulus(32'h3F800000, 32'h3F800000, 2'b00, 32'h40000000, 4'b0000, 6);
        collectResult("add_one_one", 0);
        applyStimulus(32'h3FC00000, 32'hC0000000, 2'b10, 32'hC0400000, 4'b0000, 5);
        collectResult("mul_signed", 0);
        applyStimulus(32'h3F800000, 32'h33800000, 2'b00, 32'h3F800000, 4'b0001, 6);
        collectResult("tie_even_down", 0);
        applyStimulus(32'h3F800001, 32'h33800000, 2'b00, 32'h3F800002, 4'b0001, 6);
        collectResult("tie_even_up", 0);
        applyStimulus(32'h3F800000, 32'h33800001, 2'b00, 32'h3F800001, 4'b0001, 6);
        collectResult("sticky_round_up", 0);
        applyStimulus(32'h7F800000, 32'h7F800000, 2'b01, 32'h7FC00000, 4'b1000, 2);
        collectResult("inf_minus_inf", 0);
        applyStimulus(32'h7F7FFFFF, 32'h40000000, 2'b10, 32'h7F800000, 4'b0101, 5);
        collectResult("mul_overflow", 0);
        applyStimulus(32'h7F7FFFFF, 32'h7F7FFFFF, 2'b00, 32'h7F800000, 4'b0101, 6);
        collectResult("add_overflow", 0);
        applyStimulus(32'h00800000, 32'h00800000, 2'b10, 32'h00000000, 4'b0011, 5);
        collectResult("mul_underflow", 0);
        applyStimulus(32'h3F800001, 32'h3F800000, 2'b01, 32'h34000000, 4'b0000, 6);
        collectResult("sub_cancel", 0);
        applyStimulus(32'h3F800000, 32'h40000000, 2'b01, 32'hBF800000, 4'b0000, 6);
        collectResult("sub_negative", 0);
        applyStimulus(32'h3F800000, 32'h3F800000, 2'b01, 32'h00000000, 4'b0000, 6);
        collectResult("sub_exact_zero", 0);
        applyStimulus(32'h80000000, 32'h80000000, 2'b00, 32'h80000000, 4'b0000, 6);
        collectResult("negzero_add", 0);
        applyStimulus(32'h80000000, 32'h00000000, 2'b01, 32'h80000000, 4'b0000, 6);
        collectResult("negzero_sub", 0);
        applyStimulus(32'hC0000000, 32'h00000000, 2'b10, 32'h80000000, 4'b0000, 5);
        collectResult("mul_by_zero", 0);
        applyStimulus(32'h3F800000, 32'h3F800000, 2'b11, 32'h7FC00000, 4'b1000, 2);
        collectResult("reserved_op", 0);
        applyStimulus(32'h7F800001, 32'h3F800000, 2'b00, 32'h7FC00000, 4'b1000, 2);
        collectResult("snan_input", 0);
        applyStimulus(32'h7FC00001, 32'h3F800000, 2'b00, 32'h7FC00000, 4'b0000, 2);
        collectResult("qnan_input", 0);
        applyStimulus(32'h7F800000, 32'h00000000, 2'b10, 32'h7FC00000, 4'b1000, 2);
        collectResult("zero_times_inf", 0);
        applyStimulus(32'hFF800000, 32'h40000000, 2'b10, 32'hFF800000, 4'b0000, 2);
        collectResult("mul_inf", 0);
        applyStimulus(32'h3F800000, 32'h7F800000, 2'b01, 32'hFF800000, 4'b0000, 2);
        collectResult("sub_inf", 0);

        applyStimulus(32'h40400000, 32'hBF800000, 2'b00, 32'h40000000, 4'b0000, 6);
        collectResult("backpressure", 10);

        driveOp(32'h40000000, 32'h3F800000, 2'b00);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("reset_in_align", {26'd0, in_ready, out_valid, result, flags},
                    {26'd0, 1'b1, 1'b0, 32'h0, 4'h0});
        applyStimulus(32'h40000000, 32'h40000000, 2'b00, 32'h40800000, 4'b0000, 6);
        collectResult("add_after_reset", 0);

        checkOutput("scoreboard_drained", 64'(scoreboard.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/fpu_core.md
FPU_CORE -- requirements
Module: fpu_core

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MANT_W, default 23, stored fraction width; format width W = 1+EXP_W+MANT_W.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands and op valid.
REQ-006 SHALL have port in_ready  output  1  unit can accept operation.
REQ-007 SHALL have port op_a, op_b  input  W  IEEE-754-style operands.
REQ-008 SHALL have port op  input  2  00 add, 01 sub (a-b), 10 mul, 11 reserved.
REQ-009 SHALL have port out_valid  output  1  result and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  W  packed result.
REQ-012 SHALL have port flags  output  4  {invalid, overflow, underflow, inexact}.

Function
REQ-013 SHALL accept an operation on a clock edge where in_valid && in_ready; op_a/op_b/op captured at that edge only.
REQ-014 SHALL drive in_ready high only in IDLE; one operation in flight.
REQ-015 SHALL use FSM states IDLE, CLASSIFY, ALIGN, ADD, MUL, NORM, ROUND, DONE.
REQ-016 SHALL transition IDLE->CLASSIFY on accept; CLASSIFY->DONE on special case, else ALIGN (add/sub) or MUL; ALIGN->ADD->NORM; MUL->NORM; NORM->ROUND->DONE; DONE->IDLE on out_valid && out_ready.
REQ-017 SHALL assert out_valid in DONE only: 6 cycles after accept edge for add/sub, 5 for mul, 2 for special cases.
REQ-018 SHALL hold result, flags and out_valid stable while out_valid && !out_ready.
REQ-019 SHALL treat exponent field 0 as signed zero (subnormal inputs flushed, no flag).
REQ-020 SHALL output canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0) for any NaN input, inf-inf effective subtraction, 0*inf, or op 11; invalid set for the last three and for signalling NaN inputs.
REQ-021 SHALL output correctly signed infinity for inf operands otherwise, no flags.
REQ-022 SHALL compute mul sign as XOR of operand signs; sub as add with op_b sign inverted.
REQ-023 SHALL align by right-shifting smaller-exponent significand by exponent difference, folding shifted-out bits into a sticky bit; shifts >= MANT_W+3 yield sticky only.
REQ-024 SHALL carry hidden bit plus guard, round and sticky bits through ADD/MUL/NORM.
REQ-025 SHALL normalise in one NORM cycle: right-shift by 1 on carry-out, else left-shift by leading-zero count, adjusting exponent.
REQ-026 SHALL round to nearest, ties to even, in ROUND; re-normalise if rounding carries out; inexact set when guard|round|sticky nonzero.
REQ-027 SHALL produce +0 for exact-zero add/sub of nonzero operands, -0 only for (-0)+(-0) or (-0)-(+0).
REQ-028 SHALL output signed infinity with overflow and inexact when rounded biased exponent >= 2^EXP_W-1.
REQ-029 SHALL flush results with biased exponent <= 0 to signed zero with underflow and inexact.
REQ-030 SHALL compute mul significand as full (MANT_W+1)x(MANT_W+1) product, low bits folded to sticky.

Reset
REQ-031 SHALL on reset force state IDLE, in_ready 1, out_valid 0, result 0, flags 0, overriding any in-flight operation, which is discarded.
REQ-032 SHALL ignore in_valid in the reset cycle.

Structure
REQ-033 SHALL place op encoding enum, flags struct, EXP_W/MANT_W-derived width and bias functions in shared package fpu_pkg.
REQ-034 SHALL instantiate one sub-module fpu_lzc (parametrised leading-zero counter) used by NORM.

Verification (W=32)
REQ-035 SHALL check add 0x3F800000+0x3F800000 -> 0x40000000, flags 0, out_valid 6 cycles after accept.
REQ-036 SHALL check mul 0x3FC00000*0xC0000000 -> 0xC0400000, flags 0, latency 5.
REQ-037 SHALL check add 0x3F800000+0x33800000 -> 0x3F800000 (tie to even), inexact only.
REQ-038 SHALL check sub 0x7F800000-0x7F800000 -> 0x7FC00000 invalid; mul 0x7F7FFFFF*0x40000000 -> 0x7F800000 overflow+inexact.
REQ-039 SHALL check backpressure: out_ready low 10 cycles -> result/flags stable, in_ready 0, then one transfer and in_ready 1 next cycle.
REQ-040 SHALL check reset asserted in ALIGN -> next cycle out_valid 0, in_ready 1, following add 0x40000000+0x40000000 -> 0x40800000.
